// File: rtl/dpic_sram_arbiter_if.sv
// Request/response and SRAM-side bus of the DPI-C SRAM arbiter.
// slave  : arbiter side (accepts requests, drives the SRAM pins).
// master : requester/SRAM-model side (testbench or core wrapper).
interface dpic_sram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [MASK_WIDTH-1:0] req0_wmask;
    logic [1:0]            req0_size;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  resp0_valid;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [MASK_WIDTH-1:0] req1_wmask;
    logic [1:0]            req1_size;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  resp1_valid;

    logic [DATA_WIDTH-1:0] resp_rdata;

    logic                  sram_en;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [MASK_WIDTH-1:0] sram_wmask;
    logic [1:0]            sram_size;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  req0_valid, req0_addr, req0_wmask, req0_size, req0_wdata,
        input  req1_valid, req1_addr, req1_wmask, req1_size, req1_wdata,
        input  sram_rdata,
        output req0_ready, resp0_valid, req1_ready, resp1_valid, resp_rdata,
        output sram_en, sram_addr, sram_wmask, sram_size, sram_wdata
    );

    modport master (
        output req0_valid, req0_addr, req0_wmask, req0_size, req0_wdata,
        output req1_valid, req1_addr, req1_wmask, req1_size, req1_wdata,
        output sram_rdata,
        input  req0_ready, resp0_valid, req1_ready, resp1_valid, resp_rdata,
        input  sram_en, sram_addr, sram_wmask, sram_size, sram_wdata
    );
endinterface

// File: rtl/dpic_sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the DPI-C SRAM model.
// Port 0 = instruction fetch, port 1 = load/store. One access per 2 cycles:
// accept (IDLE/RESP) -> ACCESS (sram_en) -> RESP (response pulse).
// Optional macro DPIC_ARB_PERF_EN adds 32-bit grant/conflict counters.
module dpic_sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    dpic_sram_arbiter_if.slave bus
`ifdef DPIC_ARB_PERF_EN
    ,
    output logic [31:0] perf_grant0,
    output logic [31:0] perf_grant1,
    output logic [31:0] perf_conflict
`endif
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, next_state;
    logic                  rr_last;
    logic                  gid;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [MASK_WIDTH-1:0] lat_wmask;
    logic [1:0]            lat_size;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic both_valid;
    logic accept;
    logic gnt;

    // Grant selection and next-state: accept only outside ACCESS, round-robin on conflict
    always_comb begin
        both_valid = bus.req0_valid && bus.req1_valid;
        gnt        = both_valid ? ~rr_last : bus.req1_valid;
        accept     = (state != ACCESS) && (bus.req0_valid || bus.req1_valid);
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = accept ? ACCESS : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake, response and SRAM pin outputs; sram_* fields simply hold the latched request
    always_comb begin
        bus.req0_ready  = accept && !gnt;
        bus.req1_ready  = accept && gnt;
        bus.resp0_valid = (state == RESP) && !gid;
        bus.resp1_valid = (state == RESP) && gid;
        bus.resp_rdata  = ((state == RESP) && (lat_wmask == '0)) ? bus.sram_rdata : '0;
        bus.sram_en     = (state == ACCESS);
        bus.sram_addr   = lat_addr;
        bus.sram_wmask  = lat_wmask;
        bus.sram_size   = lat_size;
        bus.sram_wdata  = lat_wdata;
    end

    // State register, round-robin pointer and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            gid       <= 1'b0;
            lat_addr  <= '0;
            lat_wmask <= '0;
            lat_size  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                rr_last   <= gnt;
                gid       <= gnt;
                lat_addr  <= gnt ? bus.req1_addr  : bus.req0_addr;
                lat_wmask <= gnt ? bus.req1_wmask : bus.req0_wmask;
                lat_size  <= gnt ? bus.req1_size  : bus.req0_size;
                lat_wdata <= gnt ? bus.req1_wdata : bus.req0_wdata;
            end
        end
    end

`ifdef DPIC_ARB_PERF_EN
    // Per-port grant and conflict counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else if (accept) begin
            if (gnt) perf_grant1 <= perf_grant1 + 32'd1;
            else     perf_grant0 <= perf_grant0 + 32'd1;
            if (both_valid) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dpic_sram_arbiter.md
Name: dpic_sram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of the DPI-C backed SRAM model. Port 0 is instruction fetch and port 1 is data load/store; both use valid/ready requests and a response pulse. The block owns the SRAM control pins (en, addr, wmask, size, wdata) and returns the SRAM's registered rdata to whichever port was granted. It sits between the core's fetch/LSU stages and the SRAM instance in the simulation top.

Parameters:
ADDR_WIDTH, 32, byte address width, shared by both ports and the SRAM.
DATA_WIDTH, 32, data width; byte-mask width is DATA_WIDTH/8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request present
req0_ready  out  1  port 0 request accepted this cycle
req0_addr  in  ADDR_WIDTH  port 0 address
req0_wmask  in  DATA_WIDTH/8  port 0 byte write mask; 0 = read
req0_size  in  2  port 0 access size (0=B, 1=H, 2=W)
req0_wdata  in  DATA_WIDTH  port 0 write data
resp0_valid  out  1  one-cycle response pulse for port 0
req1_*  (same set as req0_*, for port 1)
resp1_valid  out  1  one-cycle response pulse for port 1
resp_rdata  out  DATA_WIDTH  read data, valid when either resp*_valid is high
sram_en  out  1  SRAM access enable
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wmask  out  DATA_WIDTH/8  SRAM byte write mask
sram_size  out  2  SRAM access size
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM registered read data (1-cycle latency)

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, rr_last=1 (port 0 wins the first conflict), all outputs 0, latched request registers 0. Any in-flight access is dropped and no response is issued. Deassertion is used synchronously.
- States: IDLE, ACCESS, RESP.
- Accept rule: in IDLE or RESP, if any reqN_valid is high, grant exactly one port and assert its reqN_ready combinationally in that cycle. The granted request's addr/wmask/size/wdata and the grant id are latched; next state is ACCESS. With no valid request, IDLE stays IDLE and RESP goes to IDLE.
- Arbitration: one valid request wins outright. With both valid, grant the port != rr_last. rr_last updates to the granted port on every accept.
- ACCESS (1 cycle): sram_en=1 and sram_* driven from the latched registers. Next state is RESP.
- RESP: resp{grant}_valid=1 for exactly one cycle. resp_rdata=sram_rdata for reads and 0 for writes; writes still pulse resp as an acknowledgement. A new accept may occur in the same cycle.
- Latency: accept at cycle T, sram_en at T+1, resp pulse at T+2. Peak throughput is one access per 2 cycles.
- sram_en is 0 outside ACCESS; sram_addr/wmask/size/wdata hold their last values.
- Requesters hold request fields stable while valid && !ready. The arbiter does not check this.
- reqN_ready is never high for both ports in the same cycle. resp0_valid and resp1_valid are never high together.
- A port may re-request in the same cycle it receives its response; this is subject to normal arbitration.

Optional Feature:
DPIC_ARB_PERF_EN
- Defined: adds outputs perf_grant0, perf_grant1 and perf_conflict (32 bits each).
  - perf_grant0/perf_grant1 increment on each accept for that port.
  - perf_conflict increments on each accept cycle where both valids were high.
  - All three are cleared by reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Port 0 read only, addr=0x80000000, size=2, SRAM model returns 0xDEADBEEF -> req0_ready at T, sram_en at T+1 with addr 0x80000000, resp0_valid and resp_rdata=0xDEADBEEF at T+2.
- Port 1 write, addr=0x10, wmask=4'b0011, wdata=0x1234ABCD -> sram_en at T+1 with wmask=4'b0011, resp1_valid at T+2 with resp_rdata=0.
- Both valid continuously for 6 accepts after reset -> grant order 0,1,0,1,0,1; accepts spaced 2 cycles apart; no double ready.
- Port 0 re-requests in its RESP cycle while port 1 is idle -> port 0 accepted in the RESP cycle; second response 2 cycles after the first.
- rst_n pulled low during ACCESS -> sram_en drops to 0 immediately with no resp pulse. After release, the first conflict grants port 0.
- With DPIC_ARB_PERF_EN: 3 conflicting accepts plus 1 solo port-1 accept -> perf_grant0=2, perf_grant1=2, perf_conflict=3 (order 0,1,0 then port 1 solo).
